// File: rtl/rob_pkg.sv
// Shared types and sizing for the reorder buffer.
package rob_pkg;

    localparam int ROB_SIZE_WIDTH = 3;
    localparam int ROB_SIZE = 1 << ROB_SIZE_WIDTH;
    localparam int TAG_WIDTH = ROB_SIZE_WIDTH + 1;
    localparam int REG_NUM_WIDTH = 5;

    typedef logic [TAG_WIDTH-1:0] tag_t;

    localparam tag_t TAG_NONE = '1;

    typedef enum logic [1:0] {
        ROB_TYPE_REG    = 2'b00,
        ROB_TYPE_STORE  = 2'b01,
        ROB_TYPE_BRANCH = 2'b10,
        ROB_TYPE_HALT   = 2'b11
    } rob_type_e;

    typedef struct packed {
        logic                     busy;
        logic                     ready;
        logic                     mispredict;
        rob_type_e                kind;
        logic [REG_NUM_WIDTH-1:0] rd;
        logic [31:0]              value;
    } rob_entry_t;

    typedef struct packed {
        logic        ready;
        logic [31:0] value;
    } query_t;

endpackage

// File: rtl/rob_if.sv
// Decoder, CDB, operand-query and commit bundle of the reorder buffer.
interface rob_if;
    import rob_pkg::*;

    logic                     dec_valid_in;
    logic [1:0]               dec_type_in;
    logic [REG_NUM_WIDTH-1:0] dec_rd_in;
    logic                     dec_ready_in;
    logic [31:0]              dec_value_in;
    tag_t                     dec_tag_out;
    logic                     full_out;

    logic                     cdb_valid_in;
    tag_t                     cdb_tag_in;
    logic [31:0]              cdb_value_in;
    logic                     cdb_mispredict_in;

    tag_t                     q1_tag_in;
    tag_t                     q2_tag_in;
    logic                     q1_ready_out;
    logic                     q2_ready_out;
    logic [31:0]              q1_value_out;
    logic [31:0]              q2_value_out;

    logic                     rf_valid_out;
    logic [REG_NUM_WIDTH-1:0] rf_rd_out;
    logic [31:0]              rf_value_out;
    tag_t                     rf_dependency_out;

    logic                     store_commit_out;
    tag_t                     store_tag_out;

    logic                     flush_out;
    logic [31:0]              redirect_pc_out;
    logic                     halt_out;

    modport slave (
        input  dec_valid_in, dec_type_in, dec_rd_in,
        input  dec_ready_in, dec_value_in,
        output dec_tag_out, full_out,
        input  cdb_valid_in, cdb_tag_in, cdb_value_in,
        input  cdb_mispredict_in,
        input  q1_tag_in, q2_tag_in,
        output q1_ready_out, q2_ready_out,
        output q1_value_out, q2_value_out,
        output rf_valid_out, rf_rd_out, rf_value_out,
        output rf_dependency_out,
        output store_commit_out, store_tag_out,
        output flush_out, redirect_pc_out, halt_out
    );

    modport master (
        output dec_valid_in, dec_type_in, dec_rd_in,
        output dec_ready_in, dec_value_in,
        input  dec_tag_out, full_out,
        output cdb_valid_in, cdb_tag_in, cdb_value_in,
        output cdb_mispredict_in,
        output q1_tag_in, q2_tag_in,
        input  q1_ready_out, q2_ready_out,
        input  q1_value_out, q2_value_out,
        input  rf_valid_out, rf_rd_out, rf_value_out,
        input  rf_dependency_out,
        input  store_commit_out, store_tag_out,
        input  flush_out, redirect_pc_out, halt_out
    );

endinterface

// File: rtl/rob.sv
// Reorder buffer: circular queue allocating rename tags, collecting CDB
// results and retiring in program order with mispredict flush.
module rob
    import rob_pkg::*;
(
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic rdy_in,
    rob_if.slave bus
);

    localparam int W = ROB_SIZE_WIDTH;

    rob_entry_t ent [ROB_SIZE];

    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic [W:0]   count;
    logic         halted;

    logic                     rf_valid_q;
    logic [REG_NUM_WIDTH-1:0] rf_rd_q;
    logic [31:0]              rf_value_q;
    tag_t                     rf_dep_q;
    logic                     store_commit_q;
    tag_t                     store_tag_q;
    logic                     flush_q;
    logic [31:0]              redirect_q;

    rob_entry_t   head_e;
    logic         full;
    logic         do_commit;
    logic         do_alloc;
    logic         do_wb;
    logic         do_flush;
    logic [W-1:0] wb_idx;
    logic [W:0]   count_next;
    query_t       q1_res;
    query_t       q2_res;

    function automatic query_t lookup(
        input tag_t        q,
        input rob_entry_t  e,
        input logic        cv,
        input tag_t        ct,
        input logic [31:0] cval
    );
        query_t r;
        r.ready = 1'b0;
        r.value = '0;
        if (q == TAG_NONE) begin
            r.ready = 1'b1;
        end else if (!q[W] && e.busy && e.ready) begin
            r.ready = 1'b1;
            r.value = e.value;
        end else if (cv && ct == q) begin
            r.ready = 1'b1;
            r.value = cval;
        end
        return r;
    endfunction

    always_comb begin
        head_e = ent[head];
        full   = (count == (W+1)'(ROB_SIZE));
        wb_idx = bus.cdb_tag_in[W-1:0];
        // flush cycle drops wrong-path decode and CDB traffic
        do_wb = rdy_in && !flush_q && bus.cdb_valid_in &&
                !bus.cdb_tag_in[W] && ent[wb_idx].busy;
        do_commit = rdy_in && !halted && !flush_q &&
                    count != '0 && head_e.ready;
        do_flush = do_commit && head_e.kind == ROB_TYPE_BRANCH &&
                   head_e.mispredict;
        // a full queue still accepts when its head retires this cycle
        do_alloc = rdy_in && !halted && !flush_q &&
                   bus.dec_valid_in && (!full || do_commit);
        count_next = count + {{W{1'b0}}, do_alloc}
                           - {{W{1'b0}}, do_commit};
        q1_res = lookup(bus.q1_tag_in, ent[bus.q1_tag_in[W-1:0]],
                        bus.cdb_valid_in, bus.cdb_tag_in,
                        bus.cdb_value_in);
        q2_res = lookup(bus.q2_tag_in, ent[bus.q2_tag_in[W-1:0]],
                        bus.cdb_valid_in, bus.cdb_tag_in,
                        bus.cdb_value_in);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < ROB_SIZE; i++) ent[i] <= '0;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            halted         <= 1'b0;
            rf_valid_q     <= 1'b0;
            rf_rd_q        <= '0;
            rf_value_q     <= '0;
            rf_dep_q       <= '0;
            store_commit_q <= 1'b0;
            store_tag_q    <= '0;
            flush_q        <= 1'b0;
            redirect_q     <= '0;
        end else if (!rdy_in) begin
            rf_valid_q     <= 1'b0;
            store_commit_q <= 1'b0;
            flush_q        <= 1'b0;
        end else begin
            rf_valid_q     <= 1'b0;
            store_commit_q <= 1'b0;
            flush_q        <= 1'b0;
            if (do_wb) begin
                ent[wb_idx].ready      <= 1'b1;
                ent[wb_idx].value      <= bus.cdb_value_in;
                ent[wb_idx].mispredict <= bus.cdb_mispredict_in;
            end
            if (do_commit) begin
                ent[head].busy  <= 1'b0;
                ent[head].ready <= 1'b0;
                head            <= head + 1'b1;
                unique case (head_e.kind)
                    ROB_TYPE_REG: begin
                        rf_valid_q <= 1'b1;
                        rf_rd_q    <= head_e.rd;
                        rf_value_q <= head_e.value;
                        rf_dep_q   <= {1'b0, head};
                    end
                    ROB_TYPE_STORE: begin
                        store_commit_q <= 1'b1;
                        store_tag_q    <= {1'b0, head};
                    end
                    ROB_TYPE_BRANCH: begin
                        if (head_e.mispredict) begin
                            flush_q    <= 1'b1;
                            redirect_q <= head_e.value;
                        end
                    end
                    ROB_TYPE_HALT: halted <= 1'b1;
                endcase
            end
            if (do_alloc) begin
                ent[tail] <= '{busy: 1'b1,
                               ready: bus.dec_ready_in,
                               mispredict: 1'b0,
                               kind: rob_type_e'(bus.dec_type_in),
                               rd: bus.dec_rd_in,
                               value: bus.dec_value_in};
                tail <= tail + 1'b1;
            end
            count <= count_next;
            if (do_flush) begin
                for (int i = 0; i < ROB_SIZE; i++) begin
                    ent[i].busy  <= 1'b0;
                    ent[i].ready <= 1'b0;
                end
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end
        end
    end

    assign bus.dec_tag_out       = {1'b0, tail};
    assign bus.full_out          = full;
    assign bus.q1_ready_out      = q1_res.ready;
    assign bus.q1_value_out      = q1_res.value;
    assign bus.q2_ready_out      = q2_res.ready;
    assign bus.q2_value_out      = q2_res.value;
    assign bus.rf_valid_out      = rf_valid_q && rdy_in;
    assign bus.rf_rd_out         = rf_rd_q;
    assign bus.rf_value_out      = rf_value_q;
    assign bus.rf_dependency_out = rf_dep_q;
    assign bus.store_commit_out  = store_commit_q && rdy_in;
    assign bus.store_tag_out     = store_tag_q;
    assign bus.flush_out         = flush_q && rdy_in;
    assign bus.redirect_pc_out   = redirect_q;
    assign bus.halt_out          = halted;

endmodule

// File: tb/tb_rob.sv
// Scoreboard bench for the reorder buffer: expected retirements are queued
// at stimulus time and popped when the commit ports pulse.
module tb_rob;
    import rob_pkg::*;

    logic clk;
    logic rst_n;
    logic rdy;

    rob_if bus ();

    rob dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .rdy_in   (rdy),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [4:0]  rd;
        logic [31:0] val;
        logic [3:0]  tag;
    } ev_t;

    ev_t sb[$];
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push(input int k, input logic [4:0] rd,
                        input logic [31:0] v, input logic [3:0] t);
        ev_t e;
        e.kind = k;
        e.rd   = rd;
        e.val  = v;
        e.tag  = t;
        sb.push_back(e);
    endtask

    // commit monitor, sampled on the falling edge
    always @(negedge clk) begin
        ev_t e;
        if (rst_n && (bus.rf_valid_out || bus.store_commit_out ||
                      bus.flush_out)) begin
            if (sb.size() == 0) begin
                check("unexpected_commit",
                      64'({bus.rf_valid_out, bus.store_commit_out,
                           bus.flush_out}), 64'(0));
            end else begin
                e = sb.pop_front();
                if (e.kind == 0) begin
                    check("rf_valid", 64'(bus.rf_valid_out), 64'(1));
                    check("rf_rd", 64'(bus.rf_rd_out), 64'(e.rd));
                    check("rf_value", 64'(bus.rf_value_out), 64'(e.val));
                    check("rf_dep", 64'(bus.rf_dependency_out),
                          64'(e.tag));
                end else if (e.kind == 1) begin
                    check("store_commit", 64'(bus.store_commit_out),
                          64'(1));
                    check("store_tag", 64'(bus.store_tag_out),
                          64'(e.tag));
                end else begin
                    check("flush", 64'(bus.flush_out), 64'(1));
                    check("redirect", 64'(bus.redirect_pc_out),
                          64'(e.val));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.dec_valid_in      = 1'b0;
        bus.dec_type_in       = 2'b00;
        bus.dec_rd_in         = '0;
        bus.dec_ready_in      = 1'b0;
        bus.dec_value_in      = '0;
        bus.cdb_valid_in      = 1'b0;
        bus.cdb_tag_in        = '0;
        bus.cdb_value_in      = '0;
        bus.cdb_mispredict_in = 1'b0;
        bus.q1_tag_in         = TAG_NONE;
        bus.q2_tag_in         = TAG_NONE;
    endtask

    task automatic do_reset();
        check("sb_empty_before_reset", 64'(sb.size()), 64'(0));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        idle_inputs();
        rdy = 1'b1;
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic alloc(input logic [1:0] t, input logic [4:0] rd,
                         input logic rd_ok, input logic [31:0] v,
                         input logic [3:0] exp_tag);
        bus.dec_valid_in = 1'b1;
        bus.dec_type_in  = t;
        bus.dec_rd_in    = rd;
        bus.dec_ready_in = rd_ok;
        bus.dec_value_in = v;
        check("alloc_tag", 64'(bus.dec_tag_out), 64'(exp_tag));
        tick();
        bus.dec_valid_in = 1'b0;
    endtask

    task automatic cdb(input logic [3:0] t, input logic [31:0] v,
                       input logic mis);
        bus.cdb_valid_in      = 1'b1;
        bus.cdb_tag_in        = t;
        bus.cdb_value_in      = v;
        bus.cdb_mispredict_in = mis;
        tick();
        bus.cdb_valid_in      = 1'b0;
        bus.cdb_mispredict_in = 1'b0;
    endtask

    task automatic drain(input int max);
        for (int i = 0; i < max && sb.size() != 0; i++) tick();
        check("drain_timeout", 64'(sb.size()), 64'(0));
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        rdy   = 1'b1;
        idle_inputs();
        #3;
        check("rst_rf_valid", 64'(bus.rf_valid_out), 64'(0));
        check("rst_full", 64'(bus.full_out), 64'(0));
        check("rst_tag", 64'(bus.dec_tag_out), 64'(0));
        check("rst_halt", 64'(bus.halt_out), 64'(0));
        check("rst_flush", 64'(bus.flush_out), 64'(0));
        #4;
        rst_n = 1'b1;
        tick();

        // in-order retire with out-of-order writeback
        alloc(2'b00, 5'd5, 1'b0, 0, 4'd0);
        alloc(2'b00, 5'd6, 1'b0, 0, 4'd1);
        alloc(2'b00, 5'd7, 1'b0, 0, 4'd2);
        alloc(2'b01, 5'd0, 1'b0, 0, 4'd3);
        push(0, 5'd5, 32'h11, 4'd0);
        push(0, 5'd6, 32'h22, 4'd1);
        push(0, 5'd7, 32'h33, 4'd2);
        push(1, 5'd0, 32'h0, 4'd3);
        cdb(4'd2, 32'h33, 1'b0);
        cdb(4'd0, 32'h11, 1'b0);
        cdb(4'd1, 32'h22, 1'b0);
        cdb(4'd3, 32'h44, 1'b0);
        drain(20);
        check("order_tag_after", 64'(bus.dec_tag_out), 64'(4));

        // fill, overflow attempt, alloc+commit while full
        do_reset();
        for (int i = 0; i < 8; i++)
            alloc(2'b00, 5'(i + 1), 1'b0, 0, 4'(i));
        check("full_after_8", 64'(bus.full_out), 64'(1));
        bus.dec_valid_in = 1'b1;
        bus.dec_rd_in    = 5'd31;
        tick();
        bus.dec_valid_in = 1'b0;
        check("ninth_tag", 64'(bus.dec_tag_out), 64'(0));
        check("ninth_full", 64'(bus.full_out), 64'(1));
        for (int i = 0; i < 8; i++)
            push(0, 5'(i + 1), 32'hA0 + 32'(i), 4'(i));
        push(0, 5'd9, 32'hB9, 4'd0);
        cdb(4'd0, 32'hA0, 1'b0);
        check("full_before_swap", 64'(bus.full_out), 64'(1));
        alloc(2'b00, 5'd9, 1'b0, 0, 4'd0);
        check("full_after_swap", 64'(bus.full_out), 64'(1));
        check("tag_after_swap", 64'(bus.dec_tag_out), 64'(1));
        for (int i = 1; i < 8; i++)
            cdb(4'(i), 32'hA0 + 32'(i), 1'b0);
        cdb(4'd0, 32'hB9, 1'b0);
        drain(30);
        check("empty_full", 64'(bus.full_out), 64'(0));
        check("empty_tag", 64'(bus.dec_tag_out), 64'(1));

        // mispredicted branch flushes younger ready entry
        do_reset();
        alloc(2'b00, 5'd3, 1'b0, 0, 4'd0);
        alloc(2'b10, 5'd0, 1'b0, 0, 4'd1);
        alloc(2'b00, 5'd4, 1'b1, 32'h44, 4'd2);
        push(0, 5'd3, 32'h30, 4'd0);
        push(2, 5'd0, 32'h1000, 4'd0);
        cdb(4'd1, 32'h1000, 1'b1);
        cdb(4'd0, 32'h30, 1'b0);
        tick();
        tick();
        check("flush_now", 64'(bus.flush_out), 64'(1));
        check("flush_pc", 64'(bus.redirect_pc_out), 64'(32'h1000));
        bus.dec_valid_in = 1'b1;
        bus.dec_rd_in    = 5'd9;
        tick();
        bus.dec_valid_in = 1'b0;
        check("flush_pulse_end", 64'(bus.flush_out), 64'(0));
        check("flush_tag", 64'(bus.dec_tag_out), 64'(0));
        check("flush_full", 64'(bus.full_out), 64'(0));
        drain(10);

        // operand query bypass and stored value
        do_reset();
        for (int i = 0; i < 4; i++)
            alloc(2'b00, 5'(i + 1), 1'b0, 0, 4'(i));
        bus.q1_tag_in = 4'd3;
        bus.q2_tag_in = TAG_NONE;
        #1;
        check("q1_not_ready", 64'(bus.q1_ready_out), 64'(0));
        bus.cdb_valid_in = 1'b1;
        bus.cdb_tag_in   = 4'd3;
        bus.cdb_value_in = 32'hDEAD;
        #1;
        check("q1_byp_ready", 64'(bus.q1_ready_out), 64'(1));
        check("q1_byp_value", 64'(bus.q1_value_out), 64'(32'hDEAD));
        check("q2_none_ready", 64'(bus.q2_ready_out), 64'(1));
        check("q2_none_value", 64'(bus.q2_value_out), 64'(0));
        tick();
        bus.cdb_valid_in = 1'b0;
        #1;
        check("q1_stored_ready", 64'(bus.q1_ready_out), 64'(1));
        check("q1_stored_value", 64'(bus.q1_value_out), 64'(32'hDEAD));

        // freeze with ready head, then halt
        do_reset();
        alloc(2'b00, 5'd10, 1'b1, 32'h55, 4'd0);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("freeze_rf", 64'(bus.rf_valid_out), 64'(0));
        end
        check("freeze_tag", 64'(bus.dec_tag_out), 64'(1));
        push(0, 5'd10, 32'h55, 4'd0);
        rdy = 1'b1;
        alloc(2'b11, 5'd0, 1'b1, 0, 4'd1);
        alloc(2'b00, 5'd11, 1'b1, 32'h66, 4'd2);
        repeat (4) tick();
        check("halt_set", 64'(bus.halt_out), 64'(1));
        bus.dec_valid_in = 1'b1;
        bus.dec_rd_in    = 5'd12;
        tick();
        bus.dec_valid_in = 1'b0;
        repeat (3) tick();
        check("halt_sticky", 64'(bus.halt_out), 64'(1));
        check("halt_no_alloc", 64'(bus.dec_tag_out), 64'(3));
        check("halt_sb", 64'(sb.size()), 64'(0));

        // asynchronous reset mid-cycle
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_halt", 64'(bus.halt_out), 64'(0));
        check("async_tag", 64'(bus.dec_tag_out), 64'(0));
        check("async_rf", 64'(bus.rf_valid_out), 64'(0));
        #1;
        rst_n = 1'b1;
        tick();
        check("post_rst_full", 64'(bus.full_out), 64'(0));
        check("post_rst_tag", 64'(bus.dec_tag_out), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
